// File: rtl/mul_pkg.sv
// Shared definitions for the product accumulator: default widths, FSM state
// encoding and the packed result record presented on the result interface.
package mul_pkg;

   localparam int DEF_PROD_W    = 12;
   localparam int DEF_ACC_W     = 16;
   localparam int DEF_CNT_W     = 6;
   localparam int DEF_MAX_TERMS = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   typedef struct packed {
      logic [DEF_ACC_W-1:0] data;
      logic [DEF_CNT_W-1:0] count;
      logic                 ovf;
      logic                 trunc;
   } result_t;

endpackage

// File: rtl/mul_acc_adder.sv
// Ripple-carry accumulator adder built from full-adder cells, with carry-out.
// Define MUL_ACC_SAT_EN to clamp the sum to all-ones whenever the add carries out.
module mul_acc_adder #(
   parameter int ACC_W  = mul_pkg::DEF_ACC_W,
   parameter int PROD_W = mul_pkg::DEF_PROD_W
) (
   input  logic [ACC_W-1:0]  acc_in,
   input  logic [PROD_W-1:0] prod_in,
   output logic [ACC_W-1:0]  sum_out,
   output logic              carry_out
);

   logic [ACC_W-1:0] b_ext;
   logic [ACC_W-1:0] raw_sum;
   logic [ACC_W:0]   carry;

   assign b_ext    = ACC_W'(prod_in);
   assign carry[0] = 1'b0;

   for (genvar i = 0; i < ACC_W; i++) begin : g_fa
      assign raw_sum[i]   = acc_in[i] ^ b_ext[i] ^ carry[i];
      assign carry[i + 1] = (acc_in[i] & b_ext[i]) | (carry[i] & (acc_in[i] ^ b_ext[i]));
   end

   assign carry_out = carry[ACC_W];

`ifdef MUL_ACC_SAT_EN
   // Once pinned at all-ones, any further non-zero add carries again, so it stays pinned.
   assign sum_out = carry_out ? {ACC_W{1'b1}} : raw_sum;
`else
   assign sum_out = raw_sum;
`endif

endmodule

// File: rtl/mul_product_accumulator.sv
// Accumulates a burst of multiplier products into a dot-product sum and presents it
// on a valid/ready result port. MUL_ACC_SAT_EN selects saturating instead of wrapping adds.
module mul_product_accumulator
   import mul_pkg::*;
#(
   parameter int PROD_W    = DEF_PROD_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int MAX_TERMS = DEF_MAX_TERMS,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod_data,
   input  logic              prod_last,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_ovf,
   output logic              res_trunc
);

   // The result record is sized by the package, so the widths must agree with it.
   if (ACC_W != DEF_ACC_W || CNT_W != DEF_CNT_W || ACC_W < PROD_W ||
       MAX_TERMS < 1 || MAX_TERMS >= (1 << CNT_W)) begin : g_param_check
      $error("mul_product_accumulator: inconsistent width parameters");
   end

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   result_t          res_q, res_d;

   logic [ACC_W-1:0] sum;
   logic             carry;
   logic             beat;

   mul_acc_adder #(
      .ACC_W (ACC_W),
      .PROD_W(PROD_W)
   ) u_adder (
      .acc_in   (acc_q),
      .prod_in  (prod_data),
      .sum_out  (sum),
      .carry_out(carry)
   );

   assign prod_ready = (state_q != HOLD);
   assign res_valid  = (state_q == HOLD);
   assign beat       = prod_valid && prod_ready;

   assign res_data  = res_q.data;
   assign res_count = res_q.count;
   assign res_ovf   = res_q.ovf;
   assign res_trunc = res_q.trunc;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      res_d   = res_q;

      unique case (state_q)
         IDLE: begin
            if (beat) begin
               acc_d   = ACC_W'(prod_data);
               count_d = CNT_W'(1);
               ovf_d   = 1'b0;
               if (prod_last) begin
                  state_d = HOLD;
                  res_d   = '{data: acc_d, count: count_d, ovf: 1'b0, trunc: 1'b0};
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (beat) begin
               acc_d   = sum;
               count_d = count_q + CNT_W'(1);
               ovf_d   = ovf_q | carry;
               if (prod_last || count_d == CNT_W'(MAX_TERMS)) begin
                  state_d = HOLD;
                  res_d   = '{data: acc_d, count: count_d, ovf: ovf_d, trunc: !prod_last};
               end
            end
         end
         HOLD: begin
            if (res_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         res_q   <= res_d;
      end
   end

endmodule
